// File: rtl/ibex_lsu_pkg.sv
// ibex_lsu_pkg: shared types and helpers for the split-access load/store unit.
//   lsu_size_e : access size as log2 of the byte count
//   ls_fsm_e   : request/response sequencer states
//   be_calc    : 2*NB-bit byte-enable footprint of an access starting at a
//                beat offset; the low NB bits belong to part A, the high NB
//                bits to part B.
package ibex_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_A     = 2'd1,
    REQ_B     = 2'd2,
    WAIT_RESP = 2'd3
  } ls_fsm_e;

  // Widest supported beat is 8 bytes, so the footprint never exceeds 16 bits.
  localparam int unsigned MaxNB = 8;

  function automatic logic [2*MaxNB-1:0] be_calc(input logic [2:0]  off,
                                                  input lsu_size_e   size,
                                                  input int unsigned nb);
    logic [2*MaxNB-1:0] lane;
    logic [2*MaxNB-1:0] keep;
    lane = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
    keep = (nb >= MaxNB) ? 16'hFFFF : ((16'd1 << (2 * nb)) - 16'd1);
    return lane & keep;
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// ibex_lsu_rdata_align: combinational load-data assembly and extension.
//   rdata_a  : beat captured from part A's response
//   rdata_b  : beat on the bus in the final response cycle
//   off      : byte offset of the access inside the beat
//   size     : access size (clamped to the beat width)
//   split    : access spans two beats (A supplies the low bytes)
//   sign_ext : sign-extend from the top byte of the access
//   result   : LSB-aligned, extended load value
module ibex_lsu_rdata_align
  import ibex_lsu_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0]         rdata_a,
  input  logic [DataWidth-1:0]         rdata_b,
  input  logic [$clog2(DataWidth/8)-1:0] off,
  input  lsu_size_e                    size,
  input  logic                         split,
  input  logic                         sign_ext,
  output logic [DataWidth-1:0]         result
);

  localparam int unsigned NB   = DataWidth / 8;
  localparam int unsigned OffW = $clog2(NB);

  // Two-beat window: a split access reads A above 'off' then B from byte 0,
  // so one right shift by 'off' bytes handles both the split and single case.
  logic [2*DataWidth-1:0] cat;
  logic [DataWidth-1:0]   sh;
  logic [1:0]             sz_c;
  logic [OffW-1:0]        last;
  logic                   fill;

  assign cat  = split ? {rdata_b, rdata_a} : {{DataWidth{1'b0}}, rdata_b};
  assign sz_c = (size > 2'(OffW)) ? 2'(OffW) : size;
  assign last = OffW'((4'd1 << sz_c) - 4'd1);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [OffW:0] src;
    assign src            = (OffW+1)'(i) + {1'b0, off};
    assign sh[8*i +: 8]   = cat[{src, 3'b000} +: 8];
    assign result[8*i +: 8] = (OffW'(i) <= last) ? sh[8*i +: 8] : {8{fill}};
  end

  assign fill = sign_ext & sh[{last, 3'b111}];

endmodule

// File: rtl/ibex_lsu_split_wide.sv
// ibex_lsu_split_wide: load/store unit between EX and a 32/64-bit data bus.
// The request is registered at acceptance; misaligned accesses are split into
// part A (aligned beat) and part B (next beat), with B's request issued while
// A's response may still be in flight. Optional response timeout aborts the
// access and drains late responses before the next request is accepted.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   lsu_*_i / lsu_ready_o   : EX request channel
//   lsu_rdata_o, lsu_valid_o: completion pulse with extended load data
//   lsu_addr_last_o         : address of the last error-free granted part
//   load/store/timeout_err_o: completion error flags, qualified by valid
//   busy_o                  : access or drain in progress
//   data_*                  : data bus request/response channel
module ibex_lsu_split_wide
  import ibex_lsu_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned RespTimeout = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   lsu_req_i,
  output logic                   lsu_ready_o,
  input  logic                   lsu_we_i,
  input  logic [1:0]             lsu_size_i,
  input  logic                   lsu_sign_ext_i,
  input  logic [AddrWidth-1:0]   lsu_addr_i,
  input  logic [DataWidth-1:0]   lsu_wdata_i,
  output logic [DataWidth-1:0]   lsu_rdata_o,
  output logic                   lsu_valid_o,
  output logic [AddrWidth-1:0]   lsu_addr_last_o,
  output logic                   load_err_o,
  output logic                   store_err_o,
  output logic                   timeout_err_o,
  output logic                   busy_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  input  logic                   data_rvalid_i,
  input  logic                   data_err_i,
  input  logic                   data_pmp_err_i,
  output logic [AddrWidth-1:0]   data_addr_o,
  output logic                   data_we_o,
  output logic [DataWidth/8-1:0] data_be_o,
  output logic [DataWidth-1:0]   data_wdata_o,
  input  logic [DataWidth-1:0]   data_rdata_i
);

  localparam int unsigned NB   = DataWidth / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned BW   = 2 * NB;
  localparam int unsigned CntW = (RespTimeout < 2) ? 1 : $clog2(RespTimeout + 1);

  ls_fsm_e              state_q;
  logic [AddrWidth-1:0] addr_q, addr_last_q;
  lsu_size_e            size_q;
  logic                 we_q, sext_q, split_q, err_q;
  // a/b_out: part granted, response pending. a/b_done: part resolved by a
  // response or a PMP fault (b_done is preset for single-beat accesses).
  logic                 a_out_q, b_out_q, a_done_q, b_done_q;
  logic [DataWidth-1:0] wdata_q, rdata_a_q;
  logic [1:0]           drain_q;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [OffW-1:0]      off_q, off_in;
  logic                 split_in, illegal_in, accept;
  logic [BW-1:0]        be_full;
  logic [AddrWidth-1:0] addr_a, addr_b;
  logic                 in_req, pmp_a, pmp_b, gnt_a, gnt_b;
  logic                 outstanding, rv, rv_a, rv_b, done, tmo_fire;
  logic                 complete_err, rv_drain;
  logic [1:0]           tmo_drain;
  logic [DataWidth-1:0] rdata_ext;

  // ---------------------------------------------------------------- accept
  assign off_in      = lsu_addr_i[OffW-1:0];
  assign illegal_in  = lsu_size_i > 2'(OffW);
  assign split_in    = (5'(off_in) + (5'd1 << lsu_size_i)) > 5'(NB);
  assign lsu_ready_o = (state_q == IDLE) && (drain_q == 2'd0);
  assign accept      = lsu_req_i & lsu_ready_o;

  // ---------------------------------------------------------------- bus side
  assign off_q   = addr_q[OffW-1:0];
  assign be_full = BW'(be_calc(3'(off_q), size_q, NB));
  assign addr_a  = {addr_q[AddrWidth-1:OffW], {OffW{1'b0}}};
  assign addr_b  = addr_a + AddrWidth'(NB);

  assign in_req = (state_q == REQ_A) || (state_q == REQ_B);
  assign pmp_a  = (state_q == REQ_A) & data_pmp_err_i;
  assign pmp_b  = (state_q == REQ_B) & data_pmp_err_i;
  assign gnt_a  = (state_q == REQ_A) & ~data_pmp_err_i & data_gnt_i;
  assign gnt_b  = (state_q == REQ_B) & ~data_pmp_err_i & data_gnt_i;

  assign data_req_o  = ~rst_i & in_req & ~data_pmp_err_i;
  assign data_we_o   = we_q;
  assign data_addr_o = (state_q == REQ_B) ? addr_b : addr_a;
  assign data_be_o   = (state_q == REQ_B) ? be_full[BW-1:NB] : be_full[NB-1:0];

  // Store data is rotated so each byte lands on its lane in both beats.
  for (genvar j = 0; j < NB; j++) begin : g_wlane
    logic [OffW-1:0] src;
    assign src                   = OffW'(j) - off_q;
    assign data_wdata_o[8*j +: 8] = wdata_q[{src, 3'b000} +: 8];
  end

  // ---------------------------------------------------------------- responses
  // Responses are in order and A is always granted before B, so any rvalid
  // while A is pending belongs to A.
  assign outstanding = (state_q != IDLE) & (a_out_q | b_out_q);
  assign rv          = data_rvalid_i & outstanding;
  assign rv_a        = rv & a_out_q;
  assign rv_b        = rv & ~a_out_q & b_out_q;
  assign done        = (state_q != IDLE) & (a_done_q | pmp_a | rv_a)
                                         & (b_done_q | pmp_b | rv_b);
  assign rv_drain    = data_rvalid_i & (state_q == IDLE) & (drain_q != 2'd0);

  // Timeout counter runs only while a granted part waits on a silent bus.
  assign tmo_fire = (RespTimeout != 0) & outstanding & ~data_rvalid_i
                  & (cnt_q == CntW'(RespTimeout));
  always_comb begin
    cnt_d = cnt_q;
    if (!outstanding || data_rvalid_i)     cnt_d = '0;
    else if (cnt_q != CntW'(RespTimeout))  cnt_d = cnt_q + 1'b1;
  end
  // A B grant coinciding with the timeout is still owed a response.
  assign tmo_drain = {1'b0, a_out_q} + {1'b0, b_out_q} + {1'b0, gnt_b};

  assign complete_err = err_q | pmp_a | pmp_b | (rv & data_err_i) | tmo_fire;

  ibex_lsu_rdata_align #(.DataWidth(DataWidth)) u_align (
    .rdata_a  (rdata_a_q),
    .rdata_b  (data_rdata_i),
    .off      (off_q),
    .size     (size_q),
    .split    (split_q),
    .sign_ext (sext_q),
    .result   (rdata_ext)
  );

  assign lsu_valid_o     = ~rst_i & (done | tmo_fire);
  assign load_err_o      = lsu_valid_o & ~we_q & complete_err;
  assign store_err_o     = lsu_valid_o & we_q & complete_err;
  assign timeout_err_o   = ~rst_i & tmo_fire;
  assign lsu_rdata_o     = (lsu_valid_o & ~we_q) ? rdata_ext : '0;
  assign lsu_addr_last_o = addr_last_q;
  assign busy_o          = (state_q != IDLE) || (drain_q != 2'd0);

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_last_q <= '0;
      size_q      <= SZ_BYTE;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      a_out_q     <= 1'b0;
      b_out_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      wdata_q     <= '0;
      rdata_a_q   <= '0;
      drain_q     <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (rv_drain) drain_q     <= drain_q - 2'd1;
      if (gnt_a)    addr_last_q <= addr_q;
      if (gnt_b)    addr_last_q <= addr_b;
      if (rv_a)     rdata_a_q   <= data_rdata_i;
      if (state_q == IDLE) begin
        if (accept) begin
          addr_q   <= lsu_addr_i;
          size_q   <= lsu_size_e'(lsu_size_i);
          we_q     <= lsu_we_i;
          sext_q   <= lsu_sign_ext_i;
          wdata_q  <= lsu_wdata_i;
          split_q  <= split_in & ~illegal_in;
          a_out_q  <= 1'b0;
          b_out_q  <= 1'b0;
          // An illegal size resolves both parts up front and completes with
          // an error from WAIT_RESP without touching the bus.
          a_done_q <= illegal_in;
          b_done_q <= illegal_in | ~split_in;
          err_q    <= illegal_in;
          state_q  <= illegal_in ? WAIT_RESP : REQ_A;
        end
      end else if (done) begin
        state_q <= IDLE;
      end else if (tmo_fire) begin
        state_q <= IDLE;
        drain_q <= tmo_drain;
      end else begin
        err_q <= complete_err;
        if (rv_a)  begin a_out_q <= 1'b0; a_done_q <= 1'b1; end
        if (rv_b)  begin b_out_q <= 1'b0; b_done_q <= 1'b1; end
        if (pmp_a) a_done_q <= 1'b1;
        if (pmp_b) b_done_q <= 1'b1;
        if (gnt_a) a_out_q  <= 1'b1;
        if (gnt_b) b_out_q  <= 1'b1;
        if ((state_q == REQ_A) && (pmp_a || gnt_a))
          state_q <= split_q ? REQ_B : WAIT_RESP;
        if ((state_q == REQ_B) && (pmp_b || gnt_b))
          state_q <= WAIT_RESP;
      end
    end
  end

endmodule

// File: tb/tb_ibex_lsu_split_wide.sv
// Directed bench: a 32-bit instance with a 4-cycle response timeout and a
// 64-bit instance without timeout. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_ibex_lsu_split_wide;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit instance
  logic        req = 0, we = 0, sext = 0, gnt = 0, rvalid = 0, derr = 0, pmp = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic        ready, valid, lerr, serr, terr, busy, dreq, dwe;
  logic [31:0] rdata, alast, daddr, dwdata;
  logic [3:0]  dbe;

  ibex_lsu_split_wide #(.DataWidth(32), .AddrWidth(32), .RespTimeout(4)) dut32 (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(req), .lsu_ready_o(ready), .lsu_we_i(we),
    .lsu_size_i(size), .lsu_sign_ext_i(sext), .lsu_addr_i(addr), .lsu_wdata_i(wdata),
    .lsu_rdata_o(rdata), .lsu_valid_o(valid), .lsu_addr_last_o(alast),
    .load_err_o(lerr), .store_err_o(serr), .timeout_err_o(terr), .busy_o(busy),
    .data_req_o(dreq), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_err_i(derr),
    .data_pmp_err_i(pmp), .data_addr_o(daddr), .data_we_o(dwe), .data_be_o(dbe),
    .data_wdata_o(dwdata), .data_rdata_i(bus_rdata)
  );

  // 64-bit instance
  logic        w_req = 0, w_we = 0, w_sext = 0, w_gnt = 0, w_rvalid = 0, w_derr = 0, w_pmp = 0;
  logic [1:0]  w_size = 0;
  logic [31:0] w_addr = 0;
  logic [63:0] w_wdata = 0, w_bus_rdata = 0;
  logic        w_ready, w_valid, w_lerr, w_serr, w_terr, w_busy, w_dreq, w_dwe;
  logic [63:0] w_rdata, w_dwdata;
  logic [31:0] w_alast, w_daddr;
  logic [7:0]  w_dbe;

  ibex_lsu_split_wide #(.DataWidth(64), .AddrWidth(32), .RespTimeout(0)) dut64 (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(w_req), .lsu_ready_o(w_ready), .lsu_we_i(w_we),
    .lsu_size_i(w_size), .lsu_sign_ext_i(w_sext), .lsu_addr_i(w_addr), .lsu_wdata_i(w_wdata),
    .lsu_rdata_o(w_rdata), .lsu_valid_o(w_valid), .lsu_addr_last_o(w_alast),
    .load_err_o(w_lerr), .store_err_o(w_serr), .timeout_err_o(w_terr), .busy_o(w_busy),
    .data_req_o(w_dreq), .data_gnt_i(w_gnt), .data_rvalid_i(w_rvalid), .data_err_i(w_derr),
    .data_pmp_err_i(w_pmp), .data_addr_o(w_daddr), .data_we_o(w_dwe), .data_be_o(w_dbe),
    .data_wdata_o(w_dwdata), .data_rdata_i(w_bus_rdata)
  );

  // Present one request for a cycle; returns at the falling edge of REQ_A.
  task automatic issue(input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk); req = 1; we = w; size = sz; sext = se; addr = a; wdata = wd;
    @(negedge clk); req = 0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL rst_req_in_reset got=%0h exp=0", dreq); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid_in_reset got=%0h exp=0", valid); end
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", valid); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", dreq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (alast !== 32'h0) begin errors++; $display("FAIL rst_addr_last got=%h exp=0", alast); end
    checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_ready64 got=%0h exp=1", w_ready); end
  endtask

  task automatic test_word_load;
    issue(0, 2'd2, 0, 32'h1000, 32'h0);
    gnt = 1; #1;
    checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL wl_req got=%0h exp=1", dreq); end
    checks++; if (daddr !== 32'h1000) begin errors++; $display("FAIL wl_addr got=%h exp=00001000", daddr); end
    checks++; if (dbe !== 4'hF) begin errors++; $display("FAIL wl_be got=%h exp=f", dbe); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wl_early_valid got=%0h exp=0", valid); end
    @(negedge clk); gnt = 0; rvalid = 1; bus_rdata = 32'hDEADBEEF; #1;
    // third cycle counting the accept cycle
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wl_valid got=%0h exp=1", valid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL wl_lerr got=%0h exp=0", lerr); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wl_valid_pulse got=%0h exp=0", valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL wl_rdata_idle got=%h exp=0", rdata); end
    checks++; if (alast !== 32'h1000) begin errors++; $display("FAIL wl_addr_last got=%h exp=00001000", alast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wl_busy got=%0h exp=0", busy); end
  endtask

  task automatic load_single(input logic [31:0] a, input logic [1:0] sz, input logic se,
                             input logic [31:0] bus, input logic [3:0] exp_be,
                             input logic [31:0] exp_res);
    issue(0, sz, se, a, 32'h0);
    gnt = 1; #1;
    checks++; if (dbe !== exp_be) begin errors++; $display("FAIL sz_be a=%h got=%h exp=%h", a, dbe, exp_be); end
    @(negedge clk); gnt = 0; rvalid = 1; bus_rdata = bus; #1;
    checks++; if (rdata !== exp_res || valid !== 1'b1)
      begin errors++; $display("FAIL sz_rdata a=%h got=%h/%0h exp=%h/1", a, rdata, valid, exp_res); end
    @(negedge clk); rvalid = 0;
  endtask

  task automatic test_sizes;
    load_single(32'h3002, 2'd1, 1, 32'h80017777, 4'hC, 32'hFFFF8001);
    load_single(32'h3001, 2'd0, 0, 32'h1234F0AB, 4'h2, 32'h000000F0);
    load_single(32'h3000, 2'd0, 1, 32'h00000085, 4'h1, 32'hFFFFFF85);
  endtask

  task automatic test_misaligned_load;
    issue(0, 2'd2, 1, 32'h1003, 32'h0);
    gnt = 1; #1;
    checks++; if (daddr !== 32'h1000) begin errors++; $display("FAIL ml_addr_a got=%h exp=00001000", daddr); end
    checks++; if (dbe !== 4'h8) begin errors++; $display("FAIL ml_be_a got=%h exp=8", dbe); end
    @(negedge clk); rvalid = 1; bus_rdata = 32'hAA000000; #1;
    checks++; if (daddr !== 32'h1004) begin errors++; $display("FAIL ml_addr_b got=%h exp=00001004", daddr); end
    checks++; if (dbe !== 4'h7) begin errors++; $display("FAIL ml_be_b got=%h exp=7", dbe); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ml_early_valid got=%0h exp=0", valid); end
    @(negedge clk); gnt = 0; bus_rdata = 32'h00CCBBFF; #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ml_valid got=%0h exp=1", valid); end
    checks++; if (rdata !== 32'hCCBBFFAA) begin errors++; $display("FAIL ml_rdata got=%h exp=ccbbffaa", rdata); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (alast !== 32'h1004) begin errors++; $display("FAIL ml_addr_last got=%h exp=00001004", alast); end
  endtask

  task automatic test_split_store;
    int pulses = 0;
    issue(1, 2'd1, 0, 32'h2003, 32'h00001234);
    gnt = 1; #1;
    checks++; if (daddr !== 32'h2000 || dbe !== 4'h8 || dwe !== 1'b1)
      begin errors++; $display("FAIL ss_part_a got=%h/%h/%0h exp=00002000/8/1", daddr, dbe, dwe); end
    checks++; if (dwdata[31:24] !== 8'h34) begin errors++; $display("FAIL ss_wdata_a got=%h exp=34", dwdata[31:24]); end
    @(negedge clk); #1;
    checks++; if (daddr !== 32'h2004 || dbe !== 4'h1) begin errors++; $display("FAIL ss_part_b got=%h/%h exp=00002004/1", daddr, dbe); end
    checks++; if (dwdata[7:0] !== 8'h12) begin errors++; $display("FAIL ss_wdata_b got=%h exp=12", dwdata[7:0]); end
    @(negedge clk); gnt = 0; rvalid = 1; #1;
    if (valid) pulses++;
    @(negedge clk); #1;
    if (valid) pulses++;
    checks++; if (serr !== 1'b0 || lerr !== 1'b0) begin errors++; $display("FAIL ss_err got=%0h/%0h exp=0/0", serr, lerr); end
    @(negedge clk); rvalid = 0; #1;
    if (valid) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL ss_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_pmp_split_store;
    issue(1, 2'd2, 0, 32'h2006, 32'hCAFEF00D);
    gnt = 1; #1;
    checks++; if (dreq !== 1'b1 || daddr !== 32'h2004 || dbe !== 4'hC)
      begin errors++; $display("FAIL pmp_part_a got=%0h/%h/%h exp=1/00002004/c", dreq, daddr, dbe); end
    @(negedge clk); gnt = 0; pmp = 1; #1;
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL pmp_req_b got=%0h exp=0", dreq); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pmp_early_valid got=%0h exp=0", valid); end
    @(negedge clk); pmp = 0; rvalid = 1; #1;
    checks++; if (valid !== 1'b1 || serr !== 1'b1) begin errors++; $display("FAIL pmp_complete got=%0h/%0h exp=1/1", valid, serr); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL pmp_req_wait got=%0h exp=0", dreq); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (alast !== 32'h2006) begin errors++; $display("FAIL pmp_addr_last got=%h exp=00002006", alast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pmp_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_illegal;
    issue(0, 2'd3, 0, 32'h4000, 32'h0);
    #1;
    checks++; if (valid !== 1'b1 || lerr !== 1'b1) begin errors++; $display("FAIL ill_complete got=%0h/%0h exp=1/1", valid, lerr); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL ill_req got=%0h exp=0", dreq); end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0 || dreq !== 1'b0) begin errors++; $display("FAIL ill_after got=%0h/%0h exp=0/0", valid, dreq); end
  endtask

  task automatic test_wrap;
    issue(0, 2'd2, 0, 32'hFFFFFFFE, 32'h0);
    gnt = 1; #1;
    checks++; if (daddr !== 32'hFFFFFFFC || dbe !== 4'hC) begin errors++; $display("FAIL wrap_a got=%h/%h exp=fffffffc/c", daddr, dbe); end
    @(negedge clk); #1;
    checks++; if (daddr !== 32'h0 || dbe !== 4'h3) begin errors++; $display("FAIL wrap_b got=%h/%h exp=00000000/3", daddr, dbe); end
    @(negedge clk); gnt = 0; rvalid = 1; bus_rdata = 32'hBBAA0000;
    @(negedge clk); bus_rdata = 32'h0000DDCC; #1;
    checks++; if (valid !== 1'b1 || rdata !== 32'hDDCCBBAA) begin errors++; $display("FAIL wrap_rdata got=%0h/%h exp=1/ddccbbaa", valid, rdata); end
    @(negedge clk); rvalid = 0;
  endtask

  task automatic test_double64;
    @(negedge clk); w_req = 1; w_we = 0; w_size = 2'd3; w_sext = 0; w_addr = 32'h14;
    @(negedge clk); w_req = 0; w_gnt = 1; #1;
    checks++; if (w_daddr !== 32'h10 || w_dbe !== 8'hF0) begin errors++; $display("FAIL dbl_part_a got=%h/%h exp=00000010/f0", w_daddr, w_dbe); end
    @(negedge clk); w_rvalid = 1; w_bus_rdata = 64'h44332211_00000000; #1;
    checks++; if (w_daddr !== 32'h18 || w_dbe !== 8'h0F) begin errors++; $display("FAIL dbl_part_b got=%h/%h exp=00000018/0f", w_daddr, w_dbe); end
    @(negedge clk); w_gnt = 0; w_bus_rdata = 64'h00000000_88776655; #1;
    checks++; if (w_valid !== 1'b1 || w_rdata !== 64'h88776655_44332211)
      begin errors++; $display("FAIL dbl_rdata got=%0h/%h exp=1/8877665544332211", w_valid, w_rdata); end
    checks++; if (w_alast !== 32'h18) begin errors++; $display("FAIL dbl_addr_last got=%h exp=00000018", w_alast); end
    @(negedge clk); w_rvalid = 0;
  endtask

  task automatic test_timeout;
    issue(0, 2'd2, 0, 32'h5000, 32'h0);
    gnt = 1;
    @(negedge clk); gnt = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_early_valid cyc=%0d got=%0h exp=0", i, valid); end
      @(negedge clk);
    end
    #1;
    checks++; if (valid !== 1'b1 || lerr !== 1'b1 || terr !== 1'b1)
      begin errors++; $display("FAIL to_complete got=%0h/%0h/%0h exp=1/1/1", valid, lerr, terr); end
    @(negedge clk); #1;
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_drain_block got=%0h/%0h exp=0/1", ready, busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_valid_pulse got=%0h exp=0", valid); end
    @(negedge clk); rvalid = 1; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_late_resp got=%0h exp=0", valid); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_drained got=%0h/%0h exp=1/0", ready, busy); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    issue(0, 2'd2, 0, 32'h1003, 32'h0);
    gnt = 1;
    @(negedge clk); gnt = 0; rst = 1; #1;
    if (valid) pulses++;
    checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL rm_req got=%0h exp=0", dreq); end
    @(negedge clk); rst = 0; rvalid = 1; #1;
    if (valid) pulses++;
    checks++; if (busy !== 1'b0 || dreq !== 1'b0) begin errors++; $display("FAIL rm_idle got=%0h/%0h exp=0/0", busy, dreq); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%0h exp=1", ready); end
    @(negedge clk); rvalid = 0; #1;
    if (valid) pulses++;
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_pulses got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_sizes;
    test_misaligned_load;
    test_split_store;
    test_pmp_split_store;
    test_illegal;
    test_wrap;
    test_double64;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
